// File: rtl/adder_share_arbiter_if.sv
// Requester/result bus between the requesting blocks and the shared adder arbiter.
// master = requester/consumer side, slave = arbiter side.
interface adder_share_arbiter_if #(
  parameter int WIDTH = 31,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH:0]        result;
  logic [IDW-1:0]        res_id;
  logic                  busy;
  logic [CNT_W-1:0]      op_count;

  modport master (
    output req, a_bus, b_bus, res_ready,
    input  gnt, res_valid, result, res_id, busy, op_count
  );

  modport slave (
    input  req, a_bus, b_bus, res_ready,
    output gnt, res_valid, result, res_id, busy, op_count
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one registered sign-extending adder among NREQ requesters.
// Grant 1 cycle after request, result 1 cycle later, held until res_ready; one op in flight.
module adder_share_arbiter #(
  parameter int WIDTH = 31,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] a_s_q, a_s_d;
  logic [WIDTH-1:0] b_s_q, b_s_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;

  // Search starts one past the last winner so each requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_s_d       = a_s_q;
    b_s_d       = b_s_q;
    gnt_d       = '0;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_s_d   = bus.a_bus[win*WIDTH +: WIDTH];
          b_s_d   = bus.b_bus[win*WIDTH +: WIDTH];
          gnt_d   = NREQ'(1) << win;
          ptr_d   = win;
          state_d = ADD;
        end
      end
      ADD: begin
        result_d    = {a_s_q[WIDTH-1], a_s_q} + {b_s_q[WIDTH-1], b_s_q};
        res_id_d    = ptr_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      a_s_q       <= '0;
      b_s_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_s_q       <= a_s_d;
      b_s_q       <= b_s_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: scoreboard of expected (id, sum) pairs,
// plus a CNT_W=4 instance for counter wrap.
module tb_adder_share_arbiter;
  localparam int W = 31;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.WIDTH(W), .NREQ(N), .CNT_W(16)) ifc ();
  adder_share_arbiter_if #(.WIDTH(W), .NREQ(N), .CNT_W(4))  ifc4 ();

  adder_share_arbiter #(.WIDTH(W), .NREQ(N), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(ifc));
  adder_share_arbiter #(.WIDTH(W), .NREQ(N), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(ifc4));

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [30:0] opa[N];
  logic [30:0] opb[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sum(input logic [30:0] a, input logic [30:0] b);
    return 32'(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [30:0] a, input logic [30:0] b);
    opa[i] = a;
    opb[i] = b;
    ifc.a_bus[i*W +: W] = a;
    ifc.b_bus[i*W +: W] = b;
  endtask

  // Single-requester op with res_ready already high: checks grant/valid timing.
  task automatic do_op(input int id, input logic [30:0] a, input logic [30:0] b, input logic [31:0] exp);
    set_op(id, a, b);
    ifc.req = 4'(1 << id);
    sb.push_back('{id: 2'(id), res: exp});
    cyc();
    chk("op_gnt", 64'(ifc.gnt), 64'(1 << id));
    chk("op_busy", 64'(ifc.busy), 64'd1);
    chk("op_rv_early", 64'(ifc.res_valid), 64'd0);
    ifc.req = '0;
    cyc();
    chk("op_gnt_pulse", 64'(ifc.gnt), 64'd0);
    chk("op_rv", 64'(ifc.res_valid), 64'd1);
    cyc();
    chk("op_rv_drop", 64'(ifc.res_valid), 64'd0);
    chk("op_idle", 64'(ifc.busy), 64'd0);
  endtask

  // Scoreboard: every accepted result must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && ifc.res_valid && ifc.res_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id", 64'(ifc.res_id), 64'(e.id));
        chk("sb_result", 64'(ifc.result), 64'(e.res));
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.req = '0; ifc.a_bus = '0; ifc.b_bus = '0; ifc.res_ready = 1'b0;
    ifc4.req = '0; ifc4.a_bus = '0; ifc4.b_bus = '0; ifc4.res_ready = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_gnt", 64'(ifc.gnt), 64'd0);
    chk("rst_rv", 64'(ifc.res_valid), 64'd0);
    chk("rst_result", 64'(ifc.result), 64'd0);
    chk("rst_id", 64'(ifc.res_id), 64'd0);
    chk("rst_cnt", 64'(ifc.op_count), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    rst = 1'b0;

    // Basic op: 5 + (-7)
    ifc.res_ready = 1'b1;
    do_op(0, 31'd5, 31'h7FFF_FFF9, 32'hFFFF_FFFE);
    chk("t1_cnt", 64'(ifc.op_count), 64'd1);

    // Extremes on requester 2
    do_op(2, 31'h3FFF_FFFF, 31'h3FFF_FFFF, 32'h7FFF_FFFE);
    do_op(2, 31'h4000_0000, 31'h4000_0000, 32'h8000_0000);
    chk("t2_cnt", 64'(ifc.op_count), 64'd3);

    // Round robin from reset with everyone requesting
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 31'($urandom), 31'($urandom));
    for (int k = 0; k < 5; k++) sb.push_back('{id: 2'(k % N), res: exp_sum(opa[k % N], opb[k % N])});
    ifc.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_gnt", 64'(ifc.gnt), 64'(1 << (k % N)));
      if (k == 4) ifc.req = '0;
      cyc();
      chk("rr_gnt_gap", 64'(ifc.gnt), 64'd0);
      cyc();
    end
    chk("rr_cnt", 64'(ifc.op_count), 64'd5);

    // Backpressure: winner 1 held for 5 cycles, then winner 2 two edges after release
    ifc.res_ready = 1'b0;
    ifc.req = 4'b1111;
    sb.push_back('{id: 2'd1, res: exp_sum(opa[1], opb[1])});
    sb.push_back('{id: 2'd2, res: exp_sum(opa[2], opb[2])});
    cyc();
    chk("bp_gnt", 64'(ifc.gnt), 64'b0010);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", 64'(ifc.res_valid), 64'd1);
      chk("bp_result", 64'(ifc.result), 64'(exp_sum(opa[1], opb[1])));
      chk("bp_id", 64'(ifc.res_id), 64'd1);
      chk("bp_no_gnt", 64'(ifc.gnt), 64'd0);
      cyc();
    end
    ifc.res_ready = 1'b1;
    cyc();
    chk("bp_rv_drop", 64'(ifc.res_valid), 64'd0);
    chk("bp_gnt_wait", 64'(ifc.gnt), 64'd0);
    cyc();
    chk("bp_gnt_next", 64'(ifc.gnt), 64'b0100);
    ifc.req = '0;
    cyc(); cyc();
    chk("bp_cnt", 64'(ifc.op_count), 64'd7);

    // Reset during ADD
    ifc.res_ready = 1'b0;
    ifc.req = 4'b0001;
    cyc();
    chk("ra_gnt", 64'(ifc.gnt), 64'b0001);
    ifc.req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("ra_rv", 64'(ifc.res_valid), 64'd0);
    chk("ra_gnt0", 64'(ifc.gnt), 64'd0);
    chk("ra_cnt", 64'(ifc.op_count), 64'd0);
    chk("ra_busy", 64'(ifc.busy), 64'd0);
    cyc();
    chk("ra_discard", 64'(ifc.res_valid), 64'd0);

    // Reset during HOLD
    ifc.req = 4'b0001;
    cyc();
    ifc.req = '0;
    cyc();
    chk("rh_rv_before", 64'(ifc.res_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rh_rv", 64'(ifc.res_valid), 64'd0);
    chk("rh_gnt", 64'(ifc.gnt), 64'd0);
    chk("rh_cnt", 64'(ifc.op_count), 64'd0);
    chk("rh_busy", 64'(ifc.busy), 64'd0);

    // First grant after reset goes to requester 0
    ifc.req = 4'b1111;
    ifc.res_ready = 1'b1;
    sb.push_back('{id: 2'd0, res: exp_sum(opa[0], opb[0])});
    cyc();
    chk("rh_first_gnt", 64'(ifc.gnt), 64'b0001);
    ifc.req = '0;
    cyc(); cyc();
    chk("rh_cnt_after", 64'(ifc.op_count), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Counter wrap on the CNT_W=4 instance
    chk("w_cnt0", 64'(ifc4.op_count), 64'd0);
    ifc4.res_ready = 1'b1;
    ifc4.req = 4'b0001;
    for (int n = 1; n <= 17; n++) begin
      cyc();
      chk("w_gnt", 64'(ifc4.gnt), 64'b0001);
      cyc(); cyc();
      chk("w_cnt", 64'(ifc4.op_count), 64'(n % 16));
    end
    ifc4.req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
